instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Writer for the instruction ROM. Receives a program as a byte stream using a valid/ready handshake.
- Assembles the bytes into 32-bit words and writes them into instruction memory through a word-wide write port. Word addresses start at BASE_ADDR.
- Byte order matches the fetch path: the first byte of each word goes to the lowest address and becomes the word's MSB. Used for boot and test loading in place of the $readmemh image.

Parameters:
- BASE_ADDR, 32'hBFC00000, byte address of the first word written.
- MEM_BYTES, 4096, instruction memory size in bytes. Maximum program length is MEM_BYTES/4 words.
- CW, $clog2(MEM_BYTES/4)+1, width of the word counters (11 by default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle load request.
- rx_valid  input  1  byte-stream valid.
- rx_data  input  8  byte-stream data.
- rx_ready  output  1  loader can accept a byte.
- wr_en  output  1  memory write request.
- wr_addr  output  32  byte address of the word being written; always word-aligned.
- wr_data  output  32  word being written; the first-received byte is in [31:24].
- wr_ack  input  1  memory accepted the write.
- busy  output  1  a load is in progress.
- done  output  1  load completed successfully.
- error  output  1  header length exceeded memory capacity.
- word_count  output  CW  number of words written so far.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE immediately.
  - rx_ready, wr_en, busy, done and error are 0. wr_addr, wr_data and word_count are 0. All internal counters and shift registers are cleared.
  - Reset applies in any state, including mid-word and mid-write; any partial word is discarded.
- A byte transfers only on a rising edge where rx_valid and rx_ready are both 1. rx_data is ignored otherwise.
- All outputs are registered.
- States:
  - IDLE:
    - rx_ready=0.
    - start=1 goes to HDR and clears word_count, the byte counter and the length register.
  - HDR:
    - rx_ready=1. Collects 4 bytes, most significant first, into len (32-bit).
    - On the 4th byte: len==0 goes to DONE; len>MEM_BYTES/4 goes to ERR; otherwise DATA.
  - DATA:
    - rx_ready=1. Shifts bytes into the word register, MSB first.
    - On the 4th byte: go to WRITE. From the next cycle, wr_en=1, wr_data=assembled word and wr_addr=BASE_ADDR+4*word_count (32-bit, modulo 2^32).
  - WRITE:
    - rx_ready=0. wr_en, wr_addr and wr_data are held stable until the edge where wr_ack=1.
    - At that edge: wr_en drops, word_count increments, and the byte counter resets.
    - If the new word_count equals len, go to DONE; otherwise go to DATA.
  - DONE:
    - done=1, rx_ready=0, word_count held.
    - start goes to HDR: done cleared, counters cleared.
  - ERR:
    - error=1 (sticky), rx_ready=0, no writes are ever issued.
    - start goes to HDR: error cleared.
- start is ignored in HDR, DATA and WRITE.
- wr_ack is ignored outside WRITE.
- busy=1 exactly when the state is HDR, DATA or WRITE.
- Throughput:
  - Minimum 5 cycles per word: 4 byte transfers plus 1 WRITE cycle when wr_ack is already high.
  - wr_en rises the cycle after the 4th byte handshake.
- Boundaries:
  - len == MEM_BYTES/4 (1024) is legal. The last write is at BASE_ADDR+4092.
  - len == 1025 is an error.
  - Extra bytes after DONE are not accepted (rx_ready=0).
  - Gaps in rx_valid stall collection with no state loss.
  - Upper 21 bits of len beyond the capacity check are not otherwise used.

Test Plan:
1. Hold rst=1 asynchronously mid-cycle, then release -> all outputs 0, state IDLE, rx_ready=0 until start.
2. start, stream 00 00 00 02 DE AD BE EF 01 02 03 04, wr_ack tied 1 -> exactly two writes:
   - first: wr_addr=BFC00000, wr_data=DEADBEEF;
   - second: wr_addr=BFC00004, wr_data=01020304;
   - then done=1, word_count=2, busy=0.
3. Stream 00 00 00 00 -> done=1 the cycle after the 4th byte, wr_en never asserted, word_count=0.
4. Stream 00 00 04 01 (len=1025) -> error=1, no wr_en, rx_ready=0. Then start + 00 00 00 01 + 11 22 33 44 -> error cleared, write at BFC00000 with data 11223344, done=1.
5. rx_valid toggled with random gaps, and wr_ack delayed 3 cycles per write -> during WRITE, wr_en/wr_addr/wr_data stay stable and rx_ready=0; no byte lost or duplicated; data order correct.
6. Assert rst after 2 data bytes of word 1 -> outputs 0 immediately. Then a fresh start + 00 00 00 01 + AA BB CC DD -> write at BFC00000 with data AABBCCDD (no stale bytes).

Source files
------------

// File: rtl/instr_loader.sv
// Instruction ROM loader: takes a length-prefixed byte stream, packs it MSB-first
// into 32-bit words and writes them to instruction memory starting at BASE_ADDR.
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
    parameter int          MEM_BYTES = 4096,
    parameter int          CW        = $clog2(MEM_BYTES/4) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          wr_en,
    output logic [31:0]   wr_addr,
    output logic [31:0]   wr_data,
    input  logic          wr_ack,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / 4);

    state_t          r_state;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_len;
    logic [23:0]     r_word;
    logic [CW-1:0]   r_word_count;
    logic            r_rx_ready;
    logic            r_wr_en;
    logic [31:0]     r_wr_addr;
    logic [31:0]     r_wr_data;
    logic            r_busy;
    logic            r_done;
    logic            r_error;

    logic            w_take;
    logic            w_last_byte;
    logic [31:0]     w_len_next;
    logic [31:0]     w_word_next;
    logic [CW-1:0]   w_cnt_inc;
    logic [31:0]     w_cnt_inc_ext;
    logic [31:0]     w_addr;

    assign w_take        = r_rx_ready & rx_valid;
    assign w_last_byte   = w_take & (r_byte_cnt == 2'd3);
    assign w_len_next    = {r_len[23:0], rx_data};
    assign w_word_next   = {r_word, rx_data};
    assign w_cnt_inc     = r_word_count + {{(CW-1){1'b0}}, 1'b1};
    assign w_cnt_inc_ext = {{(32-CW){1'b0}}, w_cnt_inc};
    // Word index scaled to a byte offset; wraps modulo 2^32 with BASE_ADDR.
    assign w_addr        = BASE_ADDR + {{(30-CW){1'b0}}, r_word_count, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= 2'd0;
            r_len        <= 32'd0;
            r_word       <= 24'd0;
            r_word_count <= '0;
            r_rx_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 32'd0;
            r_wr_data    <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state      <= S_HDR;
                        r_rx_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_word_count <= '0;
                        r_byte_cnt   <= 2'd0;
                        r_len        <= 32'd0;
                        r_word       <= 24'd0;
                    end
                end
                S_HDR: begin
                    if (w_take) begin
                        r_len      <= w_len_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                    if (w_last_byte) begin
                        if (w_len_next == 32'd0) begin
                            r_state    <= S_DONE;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else if (w_len_next > MAX_WORDS) begin
                            r_state    <= S_ERR;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_take) begin
                        r_word     <= w_word_next[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                    if (w_last_byte) begin
                        r_state    <= S_WRITE;
                        r_rx_ready <= 1'b0;
                        r_wr_en    <= 1'b1;
                        r_wr_data  <= w_word_next;
                        r_wr_addr  <= w_addr;
                    end
                end
                S_WRITE: begin
                    // Address and data stay frozen until memory acknowledges.
                    if (wr_ack) begin
                        r_wr_en      <= 1'b0;
                        r_word_count <= w_cnt_inc;
                        r_byte_cnt   <= 2'd0;
                        if (w_cnt_inc_ext == r_len) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_DATA;
                            r_rx_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_rx_ready <= 1'b0;
                    r_wr_en    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready   = r_rx_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: header handling, word packing, write handshake,
// stalls, error recovery, capacity boundary and asynchronous reset.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        wr_ack = 1'b1;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] word_count;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_mode = 0;
    int ack_cnt  = 0;
    int n_bad    = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic        p_en = 1'b0;
    logic        p_ack = 1'b0;
    logic [31:0] p_addr = 32'd0;
    logic [31:0] p_data = 32'd0;

    always #5 clk = ~clk;

    instr_loader dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    // Record accepted writes; flag unstable write requests or ready during a write.
    always @(posedge clk) begin
        if (wr_en === 1'b1 && wr_ack === 1'b1) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
        if (p_en && !p_ack && !rst) begin
            if (wr_en !== 1'b1 || wr_addr !== p_addr || wr_data !== p_data) n_bad++;
        end
        if (wr_en === 1'b1 && rx_ready !== 1'b0) n_bad++;
        p_en   <= (wr_en === 1'b1);
        p_ack  <= (wr_ack === 1'b1);
        p_addr <= wr_addr;
        p_data <= wr_data;
    end

    always @(negedge clk) begin
        if (ack_mode == 0) begin
            wr_ack = 1'b1;
        end else if (wr_en === 1'b1) begin
            ack_cnt++;
            wr_ack = (ack_cnt >= 3);
        end else begin
            ack_cnt = 0;
            wr_ack  = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'hFF;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            $display("FAIL byte_timeout got rx_ready=%b want 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [79:0] v;
        #3 rst = 1'b1;
        #1;
        v = {rx_ready, wr_en, busy, done, error, wr_addr, wr_data, word_count};
        n_checks++;
        if (v !== 80'd0) $display("FAIL reset_outputs got %h want 0", v); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_ready, busy, done, error} !== 4'b0000)
            $display("FAIL idle_after_reset got %b want 0000", {rx_ready, busy, done, error});
        else n_pass++;
    endtask

    task automatic test_two_words();
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_word(32'h0000_0002, 0);
        send_word(32'hDEAD_BEEF, 0);
        send_word(32'h0102_0304, 0);
        wait_done();
        n_checks++;
        if (q_addr.size() !== 2) $display("FAIL two_count got %0d want 2", q_addr.size()); else n_pass++;
        if (q_addr.size() == 2) begin
            n_checks++;
            if (q_addr[0] !== 32'hBFC00000 || q_data[0] !== 32'hDEADBEEF)
                $display("FAIL two_w0 got %h/%h want BFC00000/DEADBEEF", q_addr[0], q_data[0]);
            else n_pass++;
            n_checks++;
            if (q_addr[1] !== 32'hBFC00004 || q_data[1] !== 32'h01020304)
                $display("FAIL two_w1 got %h/%h want BFC00004/01020304", q_addr[1], q_data[1]);
            else n_pass++;
        end
        n_checks++;
        if ({done, busy, word_count} !== {1'b1, 1'b0, 11'd2})
            $display("FAIL two_end got done=%b busy=%b wc=%0d want 1 0 2", done, busy, word_count);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_word(32'h0000_0000, 0);
        n_checks++;
        if ({done, busy, rx_ready, word_count} !== {1'b1, 1'b0, 1'b0, 11'd0})
            $display("FAIL zero_done got done=%b busy=%b rdy=%b wc=%0d want 1 0 0 0",
                     done, busy, rx_ready, word_count);
        else n_pass++;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        n_checks++;
        if ({rx_ready, done, q_addr.size() == 0} !== 3'b011)
            $display("FAIL zero_extra got rdy=%b done=%b writes=%0d want 0 1 0",
                     rx_ready, done, q_addr.size());
        else n_pass++;
    endtask

    task automatic test_error();
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_word(32'h0000_0401, 0);
        n_checks++;
        if ({error, rx_ready, busy, done} !== 4'b1000)
            $display("FAIL err_set got err=%b rdy=%b busy=%b done=%b want 1 0 0 0",
                     error, rx_ready, busy, done);
        else n_pass++;
        rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        n_checks++;
        if (error !== 1'b1 || q_addr.size() != 0 || rx_ready !== 1'b0)
            $display("FAIL err_sticky got err=%b writes=%0d want 1 0", error, q_addr.size());
        else n_pass++;
        pulse_start();
        n_checks++;
        if ({error, busy, rx_ready} !== 3'b011)
            $display("FAIL err_clear got err=%b busy=%b rdy=%b want 0 1 1", error, busy, rx_ready);
        else n_pass++;
        send_word(32'h0000_0001, 0);
        send_word(32'h1122_3344, 0);
        wait_done();
        n_checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 32'hBFC00000 || q_data[0] !== 32'h11223344 || done !== 1'b1)
            $display("FAIL err_recover got writes=%0d done=%b want 1 write BFC00000/11223344",
                     q_addr.size(), done);
        else n_pass++;
    endtask

    task automatic test_max_len();
        int errs = 0;
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_word(32'h0000_0400, 0);
        for (int i = 0; i < 1024; i++) send_word(32'h1000_0000 + 32'(i) * 32'h0001_0001, 0);
        wait_done();
        n_checks++;
        if (q_addr.size() != 1024 || word_count !== 11'd1024 || done !== 1'b1)
            $display("FAIL max_count got writes=%0d wc=%0d done=%b want 1024 1024 1",
                     q_addr.size(), word_count, done);
        else n_pass++;
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] !== 32'hBFC00000 + 32'(i) * 4 ||
                q_data[i] !== 32'h1000_0000 + 32'(i) * 32'h0001_0001) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL max_words got %0d bad words want 0", errs); else n_pass++;
        n_checks++;
        if (q_addr.size() == 0 || q_addr[q_addr.size()-1] !== 32'hBFC00FFC)
            $display("FAIL max_last_addr got %h want BFC00FFC",
                     q_addr.size() == 0 ? 32'd0 : q_addr[q_addr.size()-1]);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] exp_w[3] = '{32'hCAFE_F00D, 32'h8001_7FFE, 32'h0F1E_2D3C};
        q_addr.delete(); q_data.delete();
        n_bad    = 0;
        ack_mode = 1;
        pulse_start();
        send_word(32'h0000_0003, int'($urandom_range(0, 3)));
        for (int i = 0; i < 3; i++) begin
            send_byte(exp_w[i][31:24], int'($urandom_range(0, 3)));
            send_byte(exp_w[i][23:16], int'($urandom_range(0, 3)));
            send_byte(exp_w[i][15:8],  int'($urandom_range(0, 3)));
            send_byte(exp_w[i][7:0],   int'($urandom_range(0, 3)));
        end
        wait_done();
        ack_mode = 0;
        n_checks++;
        if (n_bad != 0) $display("FAIL stall_stable got %0d violations want 0", n_bad); else n_pass++;
        n_checks++;
        if (q_addr.size() != 3 || word_count !== 11'd3 || done !== 1'b1)
            $display("FAIL stall_count got writes=%0d wc=%0d want 3 3", q_addr.size(), word_count);
        else n_pass++;
        for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== 32'hBFC00000 + 32'(i) * 4 || q_data[i] !== exp_w[i])
                $display("FAIL stall_w%0d got %h/%h want %h/%h", i, q_addr[i], q_data[i],
                         32'hBFC00000 + 32'(i) * 4, exp_w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [79:0] v;
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_word(32'h0000_0001, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst = 1'b1;
        #1;
        v = {rx_ready, wr_en, busy, done, error, wr_addr, wr_data, word_count};
        n_checks++;
        if (v !== 80'd0) $display("FAIL midreset_outputs got %h want 0", v); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        send_word(32'h0000_0001, 0);
        send_word(32'hAABB_CCDD, 0);
        wait_done();
        n_checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 32'hBFC00000 || q_data[0] !== 32'hAABBCCDD)
            $display("FAIL midreset_write got writes=%0d want 1 write BFC00000/AABBCCDD", q_addr.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_len();
        test_error();
        test_stall();
        test_max_len();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
